// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch interface.
package imem_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam int unsigned LATENCY_MAX = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               fault;
  } imem_rsp_t;

  localparam int unsigned RSP_W = $bits(imem_rsp_t);

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO with a one-cycle flush that empties it.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [RSP_W-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [RSP_W-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [RSP_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/imem_responder.sv
// Memory side of the fetch interface: fixed-latency instruction reads with
// credit-based flow control, redirect flush and a program-load write port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  input  logic                           flush,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [INSTR_W-1:0]             rsp_instr,
  output logic [31:0]                    rsp_pc,
  output logic                           rsp_fault,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [INSTR_W-1:0]             load_data
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned FifoDepth = LATENCY + 1;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);

  logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];
  logic               rst_meta_q, rst_sync_q;
  logic               accept, rsp_hs, req_fault;
  logic [AW-1:0]      rd_idx;
  imem_rsp_t          new_rsp, head_rsp;

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RSP_W-1:0]   pipe_data_q [LATENCY];
  logic [RSP_W-1:0]   pipe_data_d [LATENCY];
  logic [CntW-1:0]    outstanding_q, outstanding_d;
  logic [RSP_W-1:0]   fifo_data;

  // State resets straight from rst_n; acceptance waits for the synchronised
  // release, so nothing moves until deassertion is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign req_ready = rst_n && rst_sync_q && !flush && !load_en &&
                     (32'(outstanding_q) < FifoDepth);
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  assign rd_idx    = req_addr[AW+1:2];
  assign req_fault = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);

  // Storage has no reset so preloaded programs survive a reset.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    new_rsp.instr = req_fault ? NOP_WORD : mem_q[rd_idx];
    new_rsp.pc    = req_addr;
    new_rsp.fault = req_fault;
  end

  always_comb begin
    pipe_vld_d  = '0;
    pipe_data_d = pipe_data_q;
    if (!flush) begin
      pipe_vld_d[0] = accept;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
    end
    if (accept) pipe_data_d[0] = new_rsp;
    for (int unsigned i = 1; i < LATENCY; i++) pipe_data_d[i] = pipe_data_q[i-1];
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (flush) begin
      outstanding_d = '0;
    end else if (accept && !rsp_hs) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accept && rsp_hs) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q    <= '0;
      outstanding_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_vld_q    <= pipe_vld_d;
      outstanding_q <= outstanding_d;
      pipe_data_q   <= pipe_data_d;
    end
  end

  imem_rsp_fifo #(
    .Depth (FifoDepth)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .push_i  (pipe_vld_q[LATENCY-1]),
    .data_i  (pipe_data_q[LATENCY-1]),
    .pop_i   (rsp_hs),
    .valid_o (rsp_valid),
    .data_o  (fifo_data)
  );

  assign head_rsp  = fifo_data;
  assign rsp_instr = head_rsp.instr;
  assign rsp_pc    = head_rsp.pc;
  assign rsp_fault = head_rsp.fault;

endmodule

// File: tb/tb_imem_responder.sv
// Randomised bench for imem_responder against a queue-based model of the fetch protocol.
module tb_imem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
  localparam int unsigned CAP   = LAT + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0, load_en = 1'b0;
  logic [31:0] req_addr = '0, load_data = '0;
  logic [7:0]  load_addr = '0;
  logic        req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_instr, rsp_pc;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  // Model: every accepted fetch not yet consumed, with the cycle it becomes visible.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    int          rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] got_q[$];
  int          cyc = 0, checks = 0, failures = 0;

  function automatic logic m_ready();
    return rst_n && !flush && !load_en && (exp_q.size() < CAP);
  endfunction

  function automatic logic m_valid();
    return rst_n && (exp_q.size() > 0) && (cyc >= exp_q[0].rdy);
  endfunction

  function automatic logic [64:0] m_head();
    if (exp_q.size() == 0) return '0;
    return {exp_q[0].instr, exp_q[0].pc, exp_q[0].fault};
  endfunction

  task automatic tick();
    logic acc, pop;
    exp_t e;
    acc = req_valid && m_ready();
    pop = m_valid() && rsp_ready;
    @(posedge clk);
    cyc++;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        e.fault = (req_addr[1:0] != 2'b00) || (req_addr >= 4 * DEPTH);
        e.instr = e.fault ? 32'h0 : mem_m[(req_addr >> 2) % DEPTH];
        e.pc    = req_addr;
        e.rdy   = cyc + LAT;
        exp_q.push_back(e);
      end
    end
    if (load_en) mem_m[load_addr] = load_data;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", rsp_instr); end
    checks++; if (rsp_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", rsp_pc); end
    checks++; if (rsp_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", rsp_fault); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b want=0", rsp_valid); end
      tick();
    end
  endtask

  task automatic test_preload();
    for (int w = 0; w < DEPTH; w++) begin
      load_en = 1'b1; load_addr = 8'(w);
      load_data = (w < 4) ? 32'hA0 + 32'(w) : $urandom;
      req_valid = 1'b1; req_addr = 32'(4 * w);
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL preload_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      tick();
    end
    load_en = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k = 0, first_acc = -1, first_rsp = -1;
    got_q.delete(); rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req_valid = (k < 4); req_addr = 32'(4 * k);
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL b2b_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      if (req_valid && req_ready) begin if (first_acc < 0) first_acc = cyc + 1; k++; end
      if (rsp_valid) begin if (first_rsp < 0) first_rsp = cyc; got_q.push_back(rsp_instr); end
      tick();
    end
    req_valid = 1'b0;
    checks++; if (first_rsp - first_acc !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", first_rsp - first_acc, LAT); end
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", got_q.size()); end
    else if (got_q[0] !== 32'hA0 || got_q[1] !== 32'hA1 || got_q[2] !== 32'hA2 || got_q[3] !== 32'hA3) begin
      failures++; $display("FAIL b2b_order got=%h %h %h %h want=a0 a1 a2 a3", got_q[0], got_q[1], got_q[2], got_q[3]);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = (i < 8) || (i == 15); req_addr = 32'(16 + 4 * i);
      if (i >= 8) rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL bp_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      if (i < 8 && req_valid && req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    checks++; if (acc != 3) begin failures++; $display("FAIL bp_accepts got=%0d want=3", acc); end
    repeat (4) tick();
  endtask

  task automatic test_flush();
    int late = 0;
    got_q.delete(); rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req_valid = (i < 2) || (i == 7); req_addr = (i == 7) ? 32'h8 : 32'(4 * i);
      flush = (i == 2);
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL flush_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL flush_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      if (rsp_valid && i >= 3 && i < 8) late++;
      if (rsp_valid) got_q.push_back(rsp_instr);
      tick();
    end
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (late != 0) begin failures++; $display("FAIL flush_killed got=%0d want=0", late); end
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL flush_count got=%0d want=1", got_q.size()); end
    else if (got_q[0] !== 32'hA2) begin failures++; $display("FAIL flush_next got=%h want=a2", got_q[0]); end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [5];
    int k = 0, nfault = 0;
    addrs = '{32'h10, 32'h2, 32'h14, 32'h400, 32'h18};
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = (k < 5); req_addr = (k < 5) ? addrs[k] : 32'h0;
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL fault_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL fault_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      if (req_valid && req_ready) k++;
      if (rsp_valid && rsp_fault && rsp_instr === 32'h0) nfault++;
      tick();
    end
    req_valid = 1'b0;
    checks++; if (nfault != 2) begin failures++; $display("FAIL fault_count got=%0d want=2", nfault); end
  endtask

  task automatic test_load_inflight();
    got_q.delete(); rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req_valid = (i == 0) || (i == 1) || (i == 6); req_addr = 32'h0;
      load_en = (i == 1); load_addr = 8'h0; load_data = 32'hBB;
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL load_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL load_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      if (i == 1) begin
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL load_block got=%b want=0", req_ready); end
      end
      if (rsp_valid) got_q.push_back(rsp_instr);
      tick();
    end
    req_valid = 1'b0; load_en = 1'b0;
    checks++;
    if (got_q.size() != 2) begin failures++; $display("FAIL load_count got=%0d want=2", got_q.size()); end
    else if (got_q[0] !== 32'hA0 || got_q[1] !== 32'hBB) begin
      failures++; $display("FAIL load_data got=%h %h want=a0 bb", got_q[0], got_q[1]);
    end
  endtask

  task automatic test_random();
    int unsigned r;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      req_valid = ($urandom_range(0, 3) != 0);
      if (r == 0)      req_addr = ($urandom & 32'h3ff) | 32'h1;
      else if (r == 1) req_addr = 32'h400 + ($urandom & 32'hffc);
      else             req_addr = {22'd0, 8'($urandom), 2'b00};
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      load_en   = ($urandom_range(0, 31) == 0);
      load_addr = 8'($urandom_range(4, 255)); load_data = $urandom;
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL rand_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      tick();
    end
    req_valid = 1'b0; flush = 1'b1; load_en = 1'b0; rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] addrs [2];
    int k = 0;
    addrs = '{32'h4, 32'hC};
    rsp_ready = 1'b0; got_q.delete();
    for (int i = 0; i < 3; i++) begin
      req_valid = (i < 2); req_addr = 32'(4 + 4 * i);
      @(negedge clk);
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL rstmid_pre cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_instr, m_valid(), m_head());
      end
      tick();
    end
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b want=0", req_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_release got=%b want=0", rsp_valid); end
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_valid = (k < 2); req_addr = (k < 2) ? addrs[k] : 32'h0;
      @(negedge clk);
      checks++; if (req_ready !== m_ready()) begin failures++; $display("FAIL rstmid_rdy cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      checks++;
      if (rsp_valid !== m_valid() || (m_valid() && {rsp_instr, rsp_pc, rsp_fault} !== m_head())) begin
        failures++; $display("FAIL rstmid_rsp cyc=%0d got=%b/%h/%h/%b want=%b/%h", cyc, rsp_valid, rsp_instr, rsp_pc, rsp_fault, m_valid(), m_head());
      end
      if (req_valid && req_ready) k++;
      if (rsp_valid) got_q.push_back(rsp_instr);
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (got_q.size() != 2) begin failures++; $display("FAIL rstmid_count got=%0d want=2", got_q.size()); end
    else if (got_q[0] !== 32'hA1 || got_q[1] !== 32'hA3) begin
      failures++; $display("FAIL rstmid_retained got=%h %h want=a1 a3", got_q[0], got_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_fault();
    test_load_inflight();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
